// File: rtl/tm_unary_add_seq.sv
// Job-level sequencer for the unary-addition tape machine: accepts a tape,
// steps the head through seek / scan / erase, and returns the result tape.
module tm_unary_add_seq #(
    parameter int TAPE_W    = 10,
    parameter int MAX_STEPS = 24,
    localparam int STEP_W   = $clog2(MAX_STEPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAPE_W-1:0] in_tape,
    input  logic              step_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAPE_W-1:0] out_tape,
    output logic [STEP_W-1:0] out_steps,
    output logic [1:0]        out_err
);
    localparam int HEAD_W = (TAPE_W > 1) ? $clog2(TAPE_W) : 1;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NO_SEP  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_EMPTY   = 2'd3;

    typedef enum logic [2:0] {IDLE, SEEK, SCAN_A, SCAN_B, ERASE, DONE} state_t;

    state_t              state_q, state_d;
    logic [TAPE_W-1:0]   tape_q, tape_d;
    logic [HEAD_W-1:0]   head_q, head_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [1:0]          err_q, err_d;
    logic                cur_bit, last;

    assign cur_bit = tape_q[head_q];
    assign last    = (head_q == HEAD_W'(TAPE_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tape_q  <= '0;
            head_q  <= '0;
            steps_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            tape_q  <= tape_d;
            head_q  <= head_d;
            steps_q <= steps_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tape_d  = tape_q;
        head_d  = head_q;
        steps_d = steps_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tape_d  = in_tape;
                    head_d  = '0;
                    steps_d = '0;
                    err_d   = ERR_OK;
                    state_d = SEEK;
                end
            end
            SEEK, SCAN_A, SCAN_B, ERASE: begin
                if (step_en) begin
                    // Budget exhaustion wins over the per-state rule and freezes the tape.
                    if (steps_q == STEP_W'(MAX_STEPS)) begin
                        state_d = DONE;
                        err_d   = ERR_TIMEOUT;
                    end else begin
                        steps_d = steps_q + 1'b1;
                        unique case (state_q)
                            SEEK: begin
                                if (cur_bit) begin
                                    state_d = SCAN_A;
                                    head_d  = head_q + 1'b1;
                                end else if (!last) begin
                                    head_d  = head_q + 1'b1;
                                end else begin
                                    state_d = DONE;
                                    err_d   = ERR_EMPTY;
                                end
                            end
                            SCAN_A: begin
                                if (cur_bit && !last) begin
                                    head_d  = head_q + 1'b1;
                                end else if (cur_bit) begin
                                    state_d = DONE;
                                    err_d   = ERR_NO_SEP;
                                end else begin
                                    // Fill the separator; head saturates on the last cell.
                                    tape_d[head_q] = 1'b1;
                                    head_d  = last ? head_q : head_q + 1'b1;
                                    state_d = SCAN_B;
                                end
                            end
                            SCAN_B: begin
                                if (cur_bit && !last) begin
                                    head_d  = head_q + 1'b1;
                                end else if (cur_bit) begin
                                    state_d = ERASE;
                                end else begin
                                    head_d  = (head_q == '0) ? head_q : head_q - 1'b1;
                                    state_d = ERASE;
                                end
                            end
                            default: begin
                                tape_d[head_q] = 1'b0;
                                state_d = DONE;
                                err_d   = ERR_OK;
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_tape  = tape_q;
    assign out_steps = steps_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_tm_unary_add_seq.sv
// Bench for tm_unary_add_seq: vector table through a scoreboard queue plus
// hand sequences for timeout, stall, backpressure and mid-job reset.
module tb_tm_unary_add_seq;
    localparam int TW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] in_tape = '0;
    logic          step_en = 1'b1;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [TW-1:0] out_tape;
    logic [4:0]    out_steps;
    logic [1:0]    out_err;

    // Small-budget instance for the timeout case.
    logic          in_valid2 = 1'b0;
    logic          in_ready2;
    logic [TW-1:0] in_tape2 = '0;
    logic          out_valid2;
    logic [TW-1:0] out_tape2;
    logic [2:0]    out_steps2;
    logic [1:0]    out_err2;

    tm_unary_add_seq #(.TAPE_W(TW), .MAX_STEPS(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_tape(in_tape), .step_en(step_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_tape(out_tape), .out_steps(out_steps),
        .out_err(out_err)
    );

    tm_unary_add_seq #(.TAPE_W(TW), .MAX_STEPS(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_tape(in_tape2), .step_en(1'b1), .out_valid(out_valid2),
        .out_ready(1'b1), .out_tape(out_tape2), .out_steps(out_steps2),
        .out_err(out_err2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tape;
        logic [TW-1:0] exp_tape;
        int            exp_steps;
        int            exp_err;
        int            exp_lat;
    } vec_t;

    typedef struct {
        logic [TW-1:0] tape;
        int            steps;
        int            err;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one job, wait (bounded) for the result, compare against the scoreboard head.
    task automatic run_job(input logic [TW-1:0] t, input exp_t e, input bit toggle, input string name);
        exp_t got;
        int   n;
        @(negedge clk);
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_tape  = t;
        step_en  = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            if (toggle) step_en = ~step_en;
            @(posedge clk); #1;
            n++;
        end
        got = sb.pop_front();
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s done: no out_valid within 200 cycles", name);
        end else begin
            chk({name, " tape"},  32'(out_tape),  32'(got.tape));
            chk({name, " steps"}, 32'(out_steps), 32'(got.steps));
            chk({name, " err"},   32'(out_err),   32'(got.err));
            if (got.lat >= 0) chk({name, " latency"}, 32'(n), 32'(got.lat));
        end
        step_en = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        exp_t e;
        int   n;
        logic [TW-1:0] hold_tape;

        vecs[0] = '{10'b0011110110, 10'b0001111110, 10, 0, 10}; // a=2 b=4
        vecs[1] = '{10'b0000000000, 10'b0000000000, 10, 3, 10}; // empty
        vecs[2] = '{10'b1100000000, 10'b1100000000, 10, 1, 10}; // no separator
        vecs[3] = '{10'b0000001110, 10'b0000001110,  7, 0,  7}; // b=0
        vecs[4] = '{10'b1111111101, 10'b0111111111, 11, 0, 11}; // b runs to last cell
        vecs[5] = '{10'b0111111110, 10'b0111111110, 12, 0, 12}; // fill at last cell

        // Reset state
        #12;
        chk("rst in_ready",  32'(in_ready),  32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_tape",  32'(out_tape),  32'd0);
        chk("rst out_steps", 32'(out_steps), 32'd0);
        chk("rst out_err",   32'(out_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            e = '{vecs[i].exp_tape, vecs[i].exp_steps, vecs[i].exp_err, vecs[i].exp_lat};
            run_job(vecs[i].tape, e, 1'b0, $sformatf("vec%0d", i));
        end

        // Stall: step_en toggling stretches time but not the step count.
        e = '{10'b0001111110, 10, 0, -1};
        run_job(10'b0011110110, e, 1'b1, "stall");

        // Timeout on the MAX_STEPS=4 instance: budget hits on the 5th enabled edge.
        @(negedge clk);
        in_valid2 = 1'b1;
        in_tape2  = 10'b0011110110;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout latency", 32'(n), 32'd5);
        chk("timeout tape",  32'(out_tape2),  32'(10'b0011111110));
        chk("timeout steps", 32'(out_steps2), 32'd4);
        chk("timeout err",   32'(out_err2),   32'd2);
        @(posedge clk); #1;
        chk("timeout back to idle", 32'(in_ready2), 32'd1);

        // Backpressure: result held, new request ignored while DONE.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_tape  = 10'b0011110110;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        hold_tape = 10'b0001111110;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) in_valid = 1'b1;
            if (c == 2) in_tape = 10'b1111111111;
            @(posedge clk); #1;
            chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d in_ready", c),  32'(in_ready),  32'd0);
            chk($sformatf("bp%0d tape", c),      32'(out_tape),  32'(hold_tape));
            chk($sformatf("bp%0d steps", c),     32'(out_steps), 32'd10);
            chk($sformatf("bp%0d err", c),       32'(out_err),   32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        chk("bp ignored req stays idle", 32'(in_ready), 32'd1);

        // Reset mid-job while in SCAN_B.
        @(negedge clk);
        in_valid = 1'b1;
        in_tape  = 10'b0011110110;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready",  32'(in_ready),  32'd1);
        chk("midrst out_tape",  32'(out_tape),  32'd0);
        chk("midrst out_steps", 32'(out_steps), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e = '{10'b0001111110, 10, 0, 10};
        run_job(10'b0011110110, e, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
